hack_rom_loader: RTL and testbench

Byte-stream loader that writes a new program image into the Hack instruction ROM while holding the CPU in reset. It is the write-side counterpart of the ROM fetch path: the CPU only reads the ROM through the program counter, and this block is the only writer. It sits between a byte source (UART receiver or debug bridge) and the ROM write port. It drives the CPU hold line so the CPU never fetches a partially loaded image.

---
 rtl/hack_loader_pkg.sv | 36 +++
 rtl/hack_loader_checksum.sv | 31 +++
 rtl/hack_rom_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_loader_pkg.sv
// Shared definitions for the Hack ROM loader: FSM state encoding, default
// ROM geometry and the byte order of words in the load stream.
package hack_loader_pkg;

    localparam int DEFAULT_ROM_ADDR_W = 15;

    // Words arrive high byte first.
    localparam logic STREAM_BIG_ENDIAN = 1'b1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHECK   = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } loader_state_t;

    // One step of the running stream checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // Build a ROM word from the two stream bytes in arrival order.
    function automatic logic [15:0] assemble_word(input logic [7:0] first, input logic [7:0] second);
        if (STREAM_BIG_ENDIAN) begin
            return {first, second};
        end else begin
            return {second, first};
        end
    endfunction

endpackage

// File: rtl/hack_loader_checksum.sv
// Running XOR over the load stream. Cleared when a load starts, folds in
// every accepted header/data byte, and compares against the trailing CHK byte.
module hack_loader_checksum
    import hack_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       accumulate,
    input  logic [7:0] data_byte,
    output logic       match
);

    logic [7:0] sum_r;

    // Accumulator: clear at load start, fold in accepted stream bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 8'h00;
        end else if (clear) begin
            sum_r <= 8'h00;
        end else if (accumulate) begin
            sum_r <= xor_fold(sum_r, data_byte);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign match = (sum_r == data_byte);

endmodule

// File: rtl/hack_rom_loader.sv
// Hack ROM loader: consumes LEN_HI, LEN_LO, N big-endian words and (when
// HACK_ROM_LOADER_CHECKSUM_EN is defined) a trailing XOR checksum byte,
// writing the words into the instruction ROM while holding the CPU in reset.
// The integrating level muxes this ROM port with the CPU fetch port and ORs
// o_CPU_Hold into the CPU reset.
module hack_rom_loader
    import hack_loader_pkg::*;
#(
    parameter int ROM_ADDR_W = DEFAULT_ROM_ADDR_W
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic                  i_Start,
    input  logic [7:0]            i_Byte,
    input  logic                  i_Byte_Valid,
    output logic                  o_Byte_Ready,
    output logic [ROM_ADDR_W-1:0] o_ROM_Address,
    output logic [15:0]           o_ROM_Data,
    output logic                  o_ROM_Write,
    output logic                  o_CPU_Hold,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    // Largest legal word count: the whole ROM.
    localparam logic [16:0] ROM_WORDS = 17'(1) << ROM_ADDR_W;

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    localparam loader_state_t TAIL_STATE = CHECK;
`else
    localparam loader_state_t TAIL_STATE = DONE;
`endif

    loader_state_t         state_r;
    loader_state_t         state_next_s;
    logic                  accept_s;
    logic                  entering_s;
    logic [15:0]           len_word_s;
    logic                  ready_next_s;
    logic                  busy_next_s;

    logic [7:0]            first_byte_r;
    logic [15:0]           remain_r;
    logic [ROM_ADDR_W-1:0] addr_r;
    logic [15:0]           data_r;
    logic                  ready_r;
    logic                  write_r;
    logic                  hold_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;

    assign accept_s   = i_Byte_Valid && ready_r;
    assign entering_s = (state_next_s != state_r);
    assign len_word_s = assemble_word(first_byte_r, i_Byte);

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    logic match_s;
    logic stream_byte_s;

    assign stream_byte_s = accept_s && ((state_r == LEN_HI) || (state_r == LEN_LO) ||
                                        (state_r == DATA_HI) || (state_r == DATA_LO));

    hack_loader_checksum u_checksum (
        .clk        (i_CLK),
        .rst        (i_RESET),
        .clear      (entering_s && (state_next_s == LEN_HI)),
        .accumulate (stream_byte_s),
        .data_byte  (i_Byte),
        .match      (match_s)
    );
`endif

    // Next-state logic for the load sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_Start) state_next_s = LEN_HI;
                else         state_next_s = IDLE;
            end
            LEN_HI: begin
                if (accept_s) state_next_s = LEN_LO;
                else          state_next_s = LEN_HI;
            end
            LEN_LO: begin
                if (!accept_s) begin
                    state_next_s = LEN_LO;
                end else if (len_word_s == 16'd0) begin
                    state_next_s = TAIL_STATE;
                end else if ({1'b0, len_word_s} > ROM_WORDS) begin
                    state_next_s = ERROR;
                end else begin
                    state_next_s = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept_s) state_next_s = DATA_LO;
                else          state_next_s = DATA_HI;
            end
            DATA_LO: begin
                if (accept_s) state_next_s = WRITE;
                else          state_next_s = DATA_LO;
            end
            WRITE: begin
                if (remain_r > 16'd1) state_next_s = DATA_HI;
                else                  state_next_s = TAIL_STATE;
            end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (!accept_s)    state_next_s = CHECK;
                else if (match_s) state_next_s = DONE;
                else              state_next_s = ERROR;
            end
`endif
            DONE, ERROR: begin
                if (i_Start) state_next_s = LEN_HI;
                else         state_next_s = state_r;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Ready/busy levels for the state being entered, registered below.
    always_comb begin
        ready_next_s = 1'b0;
        busy_next_s  = 1'b0;
        case (state_next_s)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
                ready_next_s = 1'b1;
                busy_next_s  = 1'b1;
            end
            WRITE: begin
                ready_next_s = 1'b0;
                busy_next_s  = 1'b1;
            end
            IDLE, DONE, ERROR: begin
                ready_next_s = 1'b0;
                busy_next_s  = 1'b0;
            end
            default: begin
                ready_next_s = 1'b0;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: byte capture, word counters and ROM write word.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            first_byte_r <= 8'h00;
            remain_r     <= 16'd0;
            addr_r       <= '0;
            data_r       <= 16'h0000;
        end else begin
            if (accept_s && ((state_r == LEN_HI) || (state_r == DATA_HI))) begin
                first_byte_r <= i_Byte;
            end

            if (accept_s && (state_r == LEN_LO)) begin
                remain_r <= len_word_s;
            end else if (state_r == WRITE) begin
                remain_r <= remain_r - 16'd1;
            end

            // Address follows the word counter; it steps as WRITE is left.
            if (entering_s && (state_next_s == LEN_HI)) begin
                addr_r <= '0;
            end else if (state_r == WRITE) begin
                addr_r <= addr_r + ROM_ADDR_W'(1);
            end

            if (accept_s && (state_r == DATA_LO)) begin
                data_r <= assemble_word(first_byte_r, i_Byte);
            end
        end
    end

    // Registered handshake, strobe and status outputs.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            ready_r <= 1'b0;
            write_r <= 1'b0;
            busy_r  <= 1'b0;
            hold_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            write_r <= (state_next_s == WRITE);
            busy_r  <= busy_next_s;
            if (entering_s && (state_next_s == LEN_HI)) begin
                hold_r  <= 1'b1;
                done_r  <= 1'b0;
                error_r <= 1'b0;
            end else if (entering_s && (state_next_s == DONE)) begin
                hold_r  <= 1'b0;
                done_r  <= 1'b1;
            end else if (entering_s && (state_next_s == ERROR)) begin
                // Hold stays asserted so a corrupt image never runs.
                error_r <= 1'b1;
            end
        end
    end

    assign o_Byte_Ready  = ready_r;
    assign o_ROM_Address = addr_r;
    assign o_ROM_Data    = data_r;
    assign o_ROM_Write   = write_r;
    assign o_CPU_Hold    = hold_r;
    assign o_Busy        = busy_r;
    assign o_Done        = done_r;
    assign o_Error       = error_r;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader (ROM_ADDR_W = 15).
module tb_hack_rom_loader;

    localparam int AW  = 15;
    localparam int CAP = 1 << AW;

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          i_CLK = 1'b0;
    logic          i_RESET;
    logic          i_Start;
    logic [7:0]    i_Byte;
    logic          i_Byte_Valid;
    logic          o_Byte_Ready;
    logic [AW-1:0] o_ROM_Address;
    logic [15:0]   o_ROM_Data;
    logic          o_ROM_Write;
    logic          o_CPU_Hold;
    logic          o_Busy;
    logic          o_Done;
    logic          o_Error;

    hack_rom_loader #(.ROM_ADDR_W(AW)) dut (
        .i_CLK         (i_CLK),
        .i_RESET       (i_RESET),
        .i_Start       (i_Start),
        .i_Byte        (i_Byte),
        .i_Byte_Valid  (i_Byte_Valid),
        .o_Byte_Ready  (o_Byte_Ready),
        .o_ROM_Address (o_ROM_Address),
        .o_ROM_Data    (o_ROM_Data),
        .o_ROM_Write   (o_ROM_Write),
        .o_CPU_Hold    (o_CPU_Hold),
        .o_Busy        (o_Busy),
        .o_Done        (o_Done),
        .o_Error       (o_Error)
    );

    always #5 i_CLK = ~i_CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cyc;

    logic [AW-1:0] obs_addr[$];
    logic [15:0]   obs_data[$];
    int            obs_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_CLK) cyc <= cyc + 1;

    // Record every ROM write and the first cycle o_Done is seen.
    always @(negedge i_CLK) begin
        if (o_ROM_Write === 1'b1) begin
            obs_addr.push_back(o_ROM_Address);
            obs_data.push_back(o_ROM_Data);
            obs_cyc.push_back(cyc);
        end
        if (o_Done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic pulse_start(input string name);
        @(negedge i_CLK);
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc = -1;
        check_eq({name, "_start_flags"}, {o_Byte_Ready, o_Busy, o_CPU_Hold, o_Done, o_Error},
                 5'b11100);
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid
    task automatic run_case(input string name, input logic [15:0] n, input logic [15:0] words[$],
                            input int mode, input bit corrupt);
        logic [7:0] stream[$];
        logic [7:0] x;
        bit oversize, exp_err, rdy;
        int idx, guard, gap;

        oversize = (int'(n) > CAP);
        exp_err  = oversize || (CHK_ON && corrupt);
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        if (!oversize) begin
            foreach (words[i]) begin
                stream.push_back(words[i][15:8]);
                stream.push_back(words[i][7:0]);
            end
            if (CHK_ON) begin
                x = 8'h00;
                foreach (stream[i]) x = x ^ stream[i];
                stream.push_back(corrupt ? (x ^ 8'h01) : x);
            end
        end

        pulse_start(name);
        idx = 0;
        guard = 0;
        while (idx < stream.size() && guard < 2000) begin
            i_Byte = stream[idx];
            case (mode)
                0:       i_Byte_Valid = 1'b1;
                1:       i_Byte_Valid = guard[0];
                default: i_Byte_Valid = 1'($urandom_range(0, 1));
            endcase
            rdy = o_Byte_Ready;
            @(negedge i_CLK);
            if (i_Byte_Valid && rdy) idx++;
            guard++;
        end
        i_Byte_Valid = 1'b0;
        check_eq({name, "_bytes_taken"}, idx, stream.size());
        guard = 0;
        while (o_Busy && guard < 50) begin
            @(negedge i_CLK);
            guard++;
        end
        @(negedge i_CLK);
        check_eq({name, "_idle_after"}, {o_Busy, o_Byte_Ready, o_ROM_Write}, 3'b000);
        check_eq({name, "_done"}, o_Done, !exp_err);
        check_eq({name, "_error"}, o_Error, exp_err);
        check_eq({name, "_hold"}, o_CPU_Hold, exp_err);
        check_eq({name, "_nwrites"}, obs_data.size(), oversize ? 0 : words.size());
        if (!oversize) begin
            for (int i = 0; i < words.size() && i < obs_data.size(); i++) begin
                check_eq($sformatf("%s_addr%0d", name, i), obs_addr[i], i);
                check_eq($sformatf("%s_data%0d", name, i), obs_data[i], words[i]);
                if (mode == 0 && i > 0)
                    check_eq($sformatf("%s_gap%0d", name, i), obs_cyc[i] - obs_cyc[i-1], 3);
            end
            if (mode == 0 && !exp_err && words.size() > 0 && obs_cyc.size() > 0) begin
                gap = CHK_ON ? 2 : 1;
                check_eq({name, "_done_lat"}, done_cyc - obs_cyc[obs_cyc.size()-1], gap);
            end
        end
    endtask

    logic [15:0] w[$];
    logic [7:0]  rst_stream[$];
    bit          seen, rdy0;
    int          idx0, nw;

    initial begin
        i_RESET      = 1'b1;
        i_Start      = 1'b0;
        i_Byte       = 8'h00;
        i_Byte_Valid = 1'b0;
        done_cyc     = -1;
        repeat (3) @(negedge i_CLK);
        check_eq("reset_outputs", {o_Byte_Ready, o_ROM_Write, o_CPU_Hold, o_Busy, o_Done, o_Error},
                 6'b000000);
        check_eq("reset_addr_data", {17'(o_ROM_Address), o_ROM_Data}, 33'd0);
        i_RESET = 1'b0;
        @(negedge i_CLK);

        w = '{16'h1234, 16'hABCD};
        run_case("basic", 16'd2, w, 0, 1'b0);
        run_case("toggle", 16'd2, w, 1, 1'b0);

        w = '{16'h0007};
        run_case("chk_good", 16'd1, w, 0, 1'b0);
        run_case("chk_bad", 16'd1, w, 0, 1'b1);

        w = {};
        run_case("oversize", 16'h8001, w, 0, 1'b0);
        run_case("len_ffff", 16'hFFFF, w, 2, 1'b0);
        run_case("zero", 16'd0, w, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(1, 6);
            w = {};
            for (int k = 0; k < nw; k++) w.push_back(16'($urandom));
            run_case($sformatf("rand%0d", r), 16'(nw), w, $urandom_range(0, 2),
                     1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a 4-word load, after the first write.
        pulse_start("midrst");
        rst_stream = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        idx0 = 0;
        seen = 1'b0;
        for (int g = 0; g < 100 && !seen && idx0 < rst_stream.size(); g++) begin
            i_Byte = rst_stream[idx0];
            i_Byte_Valid = 1'b1;
            rdy0 = o_Byte_Ready;
            @(negedge i_CLK);
            if (rdy0) idx0++;
            if (o_ROM_Write) seen = 1'b1;
        end
        check_eq("midrst_first_write", seen, 1'b1);
        check_eq("midrst_first_word", {17'(o_ROM_Address), o_ROM_Data}, {17'd0, 16'h1122});
        i_RESET = 1'b1;
        #1;
        check_eq("midrst_async_flags",
                 {o_Byte_Ready, o_ROM_Write, o_CPU_Hold, o_Busy, o_Done, o_Error}, 6'b000000);
        check_eq("midrst_async_addr_data", {17'(o_ROM_Address), o_ROM_Data}, 33'd0);
        i_Byte_Valid = 1'b0;
        @(negedge i_CLK);
        i_RESET = 1'b0;
        w = '{16'hBEEF, 16'h0102, 16'hF00D};
        run_case("after_rst", 16'd3, w, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
